mem_align: RTL and testbench
============================

# mem_align

Alignment and sequencing stage between the execute stage and `load_store`. It takes byte-addressed loads and stores of 1/2/4/8 bytes and turns them into 64-bit-aligned, byte-masked requests for `load_store`. Accesses that cross an 8-byte boundary are split into two sequential requests. Load data is shifted, merged, and sign- or zero-extended into the XLEN-wide writeback result.

## Interface
Parameters:
- `ALLOW_SPLIT`, default 1: when 1, boundary-crossing accesses are split in two; when 0, they raise `misaligned` and make no bus access.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `prev_stalled` in 1: low means a new op is presented this cycle. Only legal while `busy`=0.
- `busy` out 1: op in flight. Low in IDLE and in the completion cycle.
- `op_load` / `op_store` in 1 each: op type. Exactly one is high when `prev_stalled`=0.
- `op_size` in 2: 0=B, 1=H, 2=W, 3=D.
- `op_unsigned` in 1: zero-extend the load result.
- `op_addr` in XLEN: byte address.
- `op_wdata` in XLEN: store value, right-justified.
- `stall_next` out 1: low for exactly one cycle per completed op.
- `result` out XLEN: extended load data. Valid when `stall_next`=0 and the op is a load.
- `access_fault` out 1: bus fault. Valid when `stall_next`=0.
- `misaligned` out 1: split needed with `ALLOW_SPLIT`=0. Valid when `stall_next`=0.
- `ls_prev_stalled` out 1: low only in a cycle that issues a request.
- `ls_addr` out XLEN-3: aligned word address.
- `ls_do_load` / `ls_do_store` out 1 each.
- `ls_store_data` out 64; `ls_store_mask` out 8.
- `ls_stall_next` in 1; `ls_load_data` in 64; `ls_access_fault` in 1.

## Operation
- Offset `o` = `op_addr[2:0]`. Bytes `n` = 1 << `op_size`. Split when `o` + `n` > 8.
- Store alignment:
  - 128-bit data = `op_wdata` << 8·`o`.
  - 16-bit mask = ((1 << `n`) − 1) << `o`.
  - First request uses the low 64 data bits and the low 8 mask bits at word `op_addr[XLEN-1:3]`.
  - Second request uses the high halves at that word + 1, modulo 2^(XLEN-3), so the address wraps.
- Load assembly:
  - 128-bit value = {second, first} >> 8·`o`, truncated to `n` bytes.
  - The truncated value is sign-extended unless `op_unsigned`, or when `n`=8.
  - For a non-split load, second = 0.
- States:
  - IDLE: on `prev_stalled`=0:
    - non-split: issue the first request combinationally, go to FIRST.
    - split with `ALLOW_SPLIT`=1: issue the first request, go to FIRST.
    - split with `ALLOW_SPLIT`=0: issue nothing, go to MISALIGN.
  - FIRST: wait for `ls_stall_next`=0. On that cycle:
    - non-split, or `ls_access_fault`=1: complete, go to IDLE.
    - otherwise: latch `ls_load_data` as the low half, issue the second request in the same cycle, go to SECOND.
  - SECOND: on `ls_stall_next`=0, complete using the merged data, go to IDLE.
  - MISALIGN: complete with `misaligned`=1, go to IDLE.
- Completion cycle:
  - `stall_next`=0, `busy`=0.
  - `access_fault` = `ls_access_fault`, taken from the completing request.
  - A new op may be accepted and issued in this same cycle.
- The op fields (offset, size, unsigned, type, upper store data and mask, word address) are registered at accept for use by the second request and by `result`.
- A fault on the first half suppresses the second request.

## Timing
- Reset values:
  - state IDLE.
  - `busy`=0, `stall_next`=1, `ls_prev_stalled`=1, `ls_do_load`=`ls_do_store`=0.
  - `access_fault`=0, `misaligned`=0.
  - `result` is don't-care.
- First request: issued in the accept cycle (combinational forward, zero added latency).
- Non-split latency: completion in the same cycle that `load_store` lowers `stall_next`.
- Split latency: sum of the two `load_store` latencies, with the second request issued back-to-back, zero bubble.
- MISALIGN latency: completion exactly 1 cycle after accept.
- `ls_prev_stalled`=0 only in the accept cycle (for non-MISALIGN ops) and in the FIRST→SECOND transition cycle.
- Reset asserted mid-op: return to IDLE next cycle with no completion pulse. Any bus transaction already issued is owned by `load_store` reset.
- `prev_stalled`=0 while `busy`=1 is ignored; the simulation-only assert fires.

## Test plan
- LD at 0x1000, bus returns 0x1122334455667788 → one request, word 0x200, mask 0xFF; `result`=0x1122334455667788.
- LW at 0x1004, bus word 0x80000000_00000000 → `result`=0xFFFFFFFF80000000. With `op_unsigned`=1 → 0x0000000080000000.
- LD at 0x1005, words 0x0706050403020100 then 0x0F0E0D0C0B0A0908 → requests at words 0x200 then 0x201, no bubble; `result`=0x0C0B0A0908070605.
- SH at 0x1007 of 0xBEEF → first request: mask 0x80, data byte7=0xEF. Second request: mask 0x01, byte0=0xBE.
- Split LW at 0x1006 with `ls_access_fault`=1 on the first half → no second request; completion with `access_fault`=1.
- `ALLOW_SPLIT`=0, LH at 0x1007 → no request; completion 1 cycle later with `misaligned`=1. Separately, assert `rst` in SECOND → IDLE, no completion pulse, `busy`=0.

Source files
------------

// File: rtl/mem_align.sv
// Load/store alignment stage: turns byte-addressed 1/2/4/8-byte accesses into 64-bit-aligned,
// byte-masked requests, splitting boundary-crossing accesses and extending load results.
module mem_align #(
  parameter int unsigned XLEN        = 64,
  parameter bit          ALLOW_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_stalled,
  output logic              busy,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [XLEN-1:0]   op_addr,
  input  logic [XLEN-1:0]   op_wdata,
  output logic              stall_next,
  output logic [XLEN-1:0]   result,
  output logic              access_fault,
  output logic              misaligned,
  output logic              ls_prev_stalled,
  output logic [XLEN-4:0]   ls_addr,
  output logic              ls_do_load,
  output logic              ls_do_store,
  output logic [63:0]       ls_store_data,
  output logic [7:0]        ls_store_mask,
  input  logic              ls_stall_next,
  input  logic [63:0]       ls_load_data,
  input  logic              ls_access_fault
);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond, StMisalign} state_e;

  state_e          state_q, state_d;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q, load_q, store_q, split_q;
  logic [XLEN-4:0] word_q;
  logic [63:0]     hi_data_q, lo_q;
  logic [7:0]      hi_mask_q;

  logic [2:0]      off;
  logic [3:0]      nbytes;
  logic            split;
  logic [7:0]      size_mask;
  logic [15:0]     mask_al;
  logic [127:0]    data_al;
  logic            can_accept, accept, latch_lo;

  logic [63:0]     first_w, second_w, ext;
  logic [127:0]    merged;

  // Alignment of the op currently presented on the op_* inputs.
  always_comb begin
    off = op_addr[2:0];
    size_mask = 8'hFF;
    case (op_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    nbytes  = 4'd1 << op_size;
    split   = ({1'b0, off} + nbytes) > 4'd8;
    mask_al = {8'h00, size_mask} << off;
    data_al = 128'(op_wdata) << {off, 3'b000};
  end

  // Load assembly: in SECOND the low half comes from the latched first response.
  always_comb begin
    first_w  = (state_q == StSecond) ? lo_q : ls_load_data;
    second_w = (state_q == StSecond) ? ls_load_data : 64'h0;
    merged   = {second_w, first_w} >> {off_q, 3'b000};
    ext      = merged[63:0];
    case (size_q)
      2'd0:    ext = {{56{~uns_q & merged[7]}},  merged[7:0]};
      2'd1:    ext = {{48{~uns_q & merged[15]}}, merged[15:0]};
      2'd2:    ext = {{32{~uns_q & merged[31]}}, merged[31:0]};
      default: ext = merged[63:0];
    endcase
    result = ext[XLEN-1:0];
  end

  always_comb begin
    state_d         = state_q;
    busy            = (state_q != StIdle);
    stall_next      = 1'b1;
    access_fault    = 1'b0;
    misaligned      = 1'b0;
    ls_prev_stalled = 1'b1;
    ls_addr         = op_addr[XLEN-1:3];
    ls_do_load      = 1'b0;
    ls_do_store     = 1'b0;
    ls_store_data   = data_al[63:0];
    ls_store_mask   = mask_al[7:0];
    can_accept      = 1'b0;
    accept          = 1'b0;
    latch_lo        = 1'b0;
    // Outputs are held quiet while in reset so a mid-op reset never pulses completion.
    if (rst) begin
      busy = 1'b0;
    end else begin
      case (state_q)
        StIdle: can_accept = 1'b1;
        StFirst: begin
          if (!ls_stall_next) begin
            if (!split_q || ls_access_fault) begin
              stall_next   = 1'b0;
              busy         = 1'b0;
              access_fault = ls_access_fault;
              can_accept   = 1'b1;
              state_d      = StIdle;
            end else begin
              latch_lo        = 1'b1;
              ls_prev_stalled = 1'b0;
              ls_addr         = word_q + (XLEN-3)'(1);
              ls_do_load      = load_q;
              ls_do_store     = store_q;
              ls_store_data   = hi_data_q;
              ls_store_mask   = hi_mask_q;
              state_d         = StSecond;
            end
          end
        end
        StSecond: begin
          if (!ls_stall_next) begin
            stall_next   = 1'b0;
            busy         = 1'b0;
            access_fault = ls_access_fault;
            can_accept   = 1'b1;
            state_d      = StIdle;
          end
        end
        StMisalign: begin
          stall_next = 1'b0;
          busy       = 1'b0;
          misaligned = 1'b1;
          can_accept = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
      if (can_accept && !prev_stalled) begin
        accept = 1'b1;
        if (split && !ALLOW_SPLIT) begin
          state_d = StMisalign;
        end else begin
          ls_prev_stalled = 1'b0;
          ls_addr         = op_addr[XLEN-1:3];
          ls_do_load      = op_load;
          ls_do_store     = op_store;
          ls_store_data   = data_al[63:0];
          ls_store_mask   = mask_al[7:0];
          state_d         = StFirst;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      off_q     <= off;
      size_q    <= op_size;
      uns_q     <= op_unsigned;
      load_q    <= op_load;
      store_q   <= op_store;
      split_q   <= split;
      word_q    <= op_addr[XLEN-1:3];
      hi_data_q <= data_al[127:64];
      hi_mask_q <= mask_al[15:8];
    end
    if (latch_lo) lo_q <= ls_load_data;
  end

  // A new op may only be presented while the stage is not busy.
  assert property (@(posedge clk) disable iff (rst) !(busy && !prev_stalled));

endmodule

// File: tb/tb_mem_align.sv
// Randomized self-checking bench for mem_align; a byte-level memory model predicts requests
// and load results.
module tb_mem_align;
  logic        clk = 1'b0;
  logic        rst, prev_stalled, ps1, op_load, op_store, op_unsigned;
  logic [1:0]  op_size;
  logic [63:0] op_addr, op_wdata;
  logic        ls_stall_next, ls_access_fault;
  logic [63:0] ls_load_data;

  logic        busy, stall_next, access_fault, misaligned, ls_prev_stalled, ls_do_load, ls_do_store;
  logic [63:0] result, ls_store_data;
  logic [60:0] ls_addr;
  logic [7:0]  ls_store_mask;

  logic        m_busy, m_stall_next, m_access_fault, m_misaligned, m_ls_prev_stalled;
  logic        m_ls_do_load, m_ls_do_store;
  logic [63:0] m_result, m_ls_store_data;
  logic [60:0] m_ls_addr;
  logic [7:0]  m_ls_store_mask;

  int passed = 0;
  int total  = 0;
  logic [63:0] mem [logic [60:0]];

  always #5 clk = ~clk;

  mem_align #(.XLEN(64), .ALLOW_SPLIT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .prev_stalled(prev_stalled), .busy(busy),
    .op_load(op_load), .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
    .op_addr(op_addr), .op_wdata(op_wdata), .stall_next(stall_next), .result(result),
    .access_fault(access_fault), .misaligned(misaligned), .ls_prev_stalled(ls_prev_stalled),
    .ls_addr(ls_addr), .ls_do_load(ls_do_load), .ls_do_store(ls_do_store),
    .ls_store_data(ls_store_data), .ls_store_mask(ls_store_mask),
    .ls_stall_next(ls_stall_next), .ls_load_data(ls_load_data),
    .ls_access_fault(ls_access_fault)
  );

  mem_align #(.XLEN(64), .ALLOW_SPLIT(1'b0)) u_nosplit (
    .clk(clk), .rst(rst), .prev_stalled(ps1), .busy(m_busy),
    .op_load(op_load), .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
    .op_addr(op_addr), .op_wdata(op_wdata), .stall_next(m_stall_next), .result(m_result),
    .access_fault(m_access_fault), .misaligned(m_misaligned),
    .ls_prev_stalled(m_ls_prev_stalled), .ls_addr(m_ls_addr), .ls_do_load(m_ls_do_load),
    .ls_do_store(m_ls_do_store), .ls_store_data(m_ls_store_data),
    .ls_store_mask(m_ls_store_mask), .ls_stall_next(ls_stall_next),
    .ls_load_data(ls_load_data), .ls_access_fault(ls_access_fault)
  );

  function automatic logic [63:0] rd_word(input logic [60:0] w);
    if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
    return mem[w];
  endfunction

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    logic [63:0] w;
    w = rd_word(a[63:3]);
    return w[a[2:0]*8 +: 8];
  endfunction

  function automatic void wr_byte(input logic [63:0] a, input logic [7:0] b);
    logic [63:0] w;
    w = rd_word(a[63:3]);
    w[a[2:0]*8 +: 8] = b;
    mem[a[63:3]] = w;
  endfunction

  // Little-endian read of n bytes, then extension.
  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] sz,
                                           input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = rd_byte(addr + 64'(i));
    if (!uns && n < 8 && v[n*8-1]) for (int i = n*8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] bytes_of(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic idle_inputs();
    prev_stalled = 1'b1; ps1 = 1'b1; op_load = 1'b0; op_store = 1'b0;
    ls_stall_next = 1'b1; ls_access_fault = 1'b0; ls_load_data = {$urandom, $urandom};
  endtask

  // Runs one op on u_dut starting at the current (post-negedge) time. With chain_next the
  // call returns inside the completion cycle so the next op is accepted in that same cycle.
  task automatic do_op(input bit ld, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                       input logic [63:0] wd, input int lat1, input int lat2, input bit f1,
                       input bit f2, input bit chain_next);
    int n;
    bit split, fexp;
    logic [60:0] w0, w1;
    logic [7:0] em [2];
    logic [63:0] ed [2];
    logic [63:0] a, exp_res;
    int k;
    n = 1 << sz;
    split = (int'(addr[2:0]) + n) > 8;
    w0 = addr[63:3];
    w1 = w0 + 61'd1;
    em[0] = '0; em[1] = '0; ed[0] = '0; ed[1] = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 64'(i);
      k = (a[63:3] == w0) ? 0 : 1;
      em[k][a[2:0]] = 1'b1;
      ed[k][a[2:0]*8 +: 8] = wd[i*8 +: 8];
    end
    exp_res = ref_load(addr, sz, uns);

    prev_stalled = 1'b0; op_load = ld; op_store = !ld; op_size = sz; op_unsigned = uns;
    op_addr = addr; op_wdata = wd;
    #1;
    total++; if (ls_prev_stalled !== 1'b0) $display("FAIL acc_issue: ls_prev_stalled=%b want 0", ls_prev_stalled); else passed++;
    total++; if (ls_addr !== w0) $display("FAIL acc_addr: ls_addr=%h want %h", ls_addr, w0); else passed++;
    total++; if ({ls_do_load, ls_do_store} !== {ld, !ld}) $display("FAIL acc_kind: ld/st=%b%b want %b%b", ls_do_load, ls_do_store, ld, !ld); else passed++;
    if (!ld) begin
      total++; if (ls_store_mask !== em[0]) $display("FAIL acc_mask: mask=%h want %h", ls_store_mask, em[0]); else passed++;
      total++; if ((ls_store_data & bytes_of(em[0])) !== ed[0]) $display("FAIL acc_data: data=%h want %h (mask %h)", ls_store_data, ed[0], em[0]); else passed++;
    end
    @(negedge clk);
    prev_stalled = 1'b1; op_addr = {$urandom, $urandom}; op_wdata = {$urandom, $urandom};
    op_size = 2'($urandom); op_unsigned = 1'($urandom);

    for (int c = 1; c <= lat1; c++) begin
      ls_stall_next = (c != lat1);
      ls_load_data = (c == lat1) ? rd_word(w0) : {$urandom, $urandom};
      ls_access_fault = (c == lat1) ? f1 : 1'b0;
      #1;
      if (c != lat1) begin
        total++; if ({stall_next, busy, ls_prev_stalled} !== 3'b111) $display("FAIL wait1: stall_next/busy/ls_ps=%b want 111", {stall_next, busy, ls_prev_stalled}); else passed++;
        @(negedge clk);
      end
    end
    fexp = f1;
    if (split && !f1) begin
      total++; if (ls_prev_stalled !== 1'b0) $display("FAIL sec_issue: ls_prev_stalled=%b want 0", ls_prev_stalled); else passed++;
      total++; if (ls_addr !== w1) $display("FAIL sec_addr: ls_addr=%h want %h", ls_addr, w1); else passed++;
      total++; if ({stall_next, busy} !== 2'b11) $display("FAIL sec_busy: stall_next/busy=%b want 11", {stall_next, busy}); else passed++;
      total++; if ({ls_do_load, ls_do_store} !== {ld, !ld}) $display("FAIL sec_kind: ld/st=%b%b want %b%b", ls_do_load, ls_do_store, ld, !ld); else passed++;
      if (!ld) begin
        total++; if (ls_store_mask !== em[1]) $display("FAIL sec_mask: mask=%h want %h", ls_store_mask, em[1]); else passed++;
        total++; if ((ls_store_data & bytes_of(em[1])) !== ed[1]) $display("FAIL sec_data: data=%h want %h", ls_store_data, ed[1]); else passed++;
      end
      @(negedge clk);
      for (int c = 1; c <= lat2; c++) begin
        ls_stall_next = (c != lat2);
        ls_load_data = (c == lat2) ? rd_word(w1) : {$urandom, $urandom};
        ls_access_fault = (c == lat2) ? f2 : 1'b0;
        #1;
        if (c != lat2) begin
          total++; if ({stall_next, busy, ls_prev_stalled} !== 3'b111) $display("FAIL wait2: stall_next/busy/ls_ps=%b want 111", {stall_next, busy, ls_prev_stalled}); else passed++;
          @(negedge clk);
        end
      end
      fexp = f2;
    end

    total++; if ({stall_next, busy} !== 2'b00) $display("FAIL done: stall_next/busy=%b want 00", {stall_next, busy}); else passed++;
    total++; if (access_fault !== fexp) $display("FAIL done_fault: access_fault=%b want %b", access_fault, fexp); else passed++;
    total++; if (misaligned !== 1'b0) $display("FAIL done_misal: misaligned=%b want 0", misaligned); else passed++;
    total++; if (ls_prev_stalled !== 1'b1) $display("FAIL done_noissue: ls_prev_stalled=%b want 1", ls_prev_stalled); else passed++;
    if (ld && !fexp) begin
      total++; if (result !== exp_res) $display("FAIL result: addr=%h size=%0d uns=%b result=%h want %h", addr, sz, uns, result, exp_res); else passed++;
    end
    if (!ld && !fexp) for (int i = 0; i < n; i++) wr_byte(addr + 64'(i), wd[i*8 +: 8]);

    if (!chain_next) begin
      @(negedge clk);
      ls_stall_next = 1'b1; ls_access_fault = 1'b0;
      #1;
      total++; if ({stall_next, busy} !== 2'b10) $display("FAIL after_done: stall_next/busy=%b want 10", {stall_next, busy}); else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({busy, stall_next, ls_prev_stalled, ls_do_load, ls_do_store} !== 5'b01100) $display("FAIL reset_ctl: busy/sn/lsps/ld/st=%b want 01100", {busy, stall_next, ls_prev_stalled, ls_do_load, ls_do_store}); else passed++;
    total++; if ({access_fault, misaligned} !== 2'b00) $display("FAIL reset_flags: fault/misal=%b want 00", {access_fault, misaligned}); else passed++;
  endtask

  task automatic test_directed();
    mem[61'h200] = 64'h1122334455667788;
    do_op(1'b1, 2'd3, 1'b0, 64'h1000, 64'h0, 1, 1, 1'b0, 1'b0, 1'b0);
    mem[61'h200] = 64'h8000000000000000;
    do_op(1'b1, 2'd2, 1'b0, 64'h1004, 64'h0, 2, 1, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 2'd2, 1'b1, 64'h1004, 64'h0, 1, 1, 1'b0, 1'b0, 1'b0);
    mem[61'h200] = 64'h0706050403020100;
    mem[61'h201] = 64'h0F0E0D0C0B0A0908;
    do_op(1'b1, 2'd3, 1'b0, 64'h1005, 64'h0, 1, 1, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 2'd1, 1'b0, 64'h1007, 64'h123456789ABCBEEF, 1, 2, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 2'd2, 1'b0, 64'h1006, 64'h0, 2, 1, 1'b1, 1'b0, 1'b0);
    do_op(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 1, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 64'h3000 + 64'($urandom_range(0, 200)),
            {$urandom, $urandom}, $urandom_range(1, 3), $urandom_range(1, 3),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++)
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 64'h3000 + 64'($urandom_range(0, 64)),
            {$urandom, $urandom}, $urandom_range(1, 2), $urandom_range(1, 2),
            $urandom_range(0, 7) == 0, 1'b0, i != 29);
  endtask

  task automatic test_misalign();
    logic [63:0] addrs [4];
    logic [1:0]  sizes [4];
    addrs[0] = 64'h1007; sizes[0] = 2'd1;
    addrs[1] = 64'h2000 + 64'($urandom_range(1, 7)); sizes[1] = 2'd3;
    addrs[2] = 64'h2100 + 64'($urandom_range(5, 7)); sizes[2] = 2'd2;
    addrs[3] = 64'h2207; sizes[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      ps1 = 1'b0; op_load = 1'b1; op_store = 1'b0; op_size = sizes[i]; op_addr = addrs[i];
      op_unsigned = 1'b0;
      #1;
      total++; if ({m_ls_prev_stalled, m_ls_do_load, m_stall_next} !== 3'b101) $display("FAIL mis_acc: lsps/ld/sn=%b want 101", {m_ls_prev_stalled, m_ls_do_load, m_stall_next}); else passed++;
      @(negedge clk);
      ps1 = 1'b1;
      #1;
      total++; if ({m_stall_next, m_busy, m_misaligned, m_access_fault} !== 4'b0010) $display("FAIL mis_done: sn/busy/misal/fault=%b want 0010", {m_stall_next, m_busy, m_misaligned, m_access_fault}); else passed++;
      @(negedge clk);
      #1;
      total++; if ({m_stall_next, m_misaligned} !== 2'b10) $display("FAIL mis_after: sn/misal=%b want 10", {m_stall_next, m_misaligned}); else passed++;
    end
  endtask

  task automatic test_reset_mid_op();
    prev_stalled = 1'b0; op_load = 1'b1; op_store = 1'b0; op_size = 2'd3; op_addr = 64'h2003;
    #1;
    @(negedge clk);
    prev_stalled = 1'b1; ls_stall_next = 1'b0; ls_access_fault = 1'b0; ls_load_data = rd_word(61'h400);
    #1;
    total++; if (ls_prev_stalled !== 1'b0) $display("FAIL rst_sec_issue: ls_prev_stalled=%b want 0", ls_prev_stalled); else passed++;
    @(negedge clk);
    rst = 1'b1; ls_stall_next = 1'b0;
    #1;
    total++; if (stall_next !== 1'b1) $display("FAIL rst_no_pulse: stall_next=%b want 1", stall_next); else passed++;
    @(negedge clk);
    rst = 1'b0; ls_stall_next = 1'b1;
    #1;
    total++; if ({busy, stall_next, ls_prev_stalled} !== 3'b011) $display("FAIL rst_idle: busy/sn/lsps=%b want 011", {busy, stall_next, ls_prev_stalled}); else passed++;
    do_op(1'b1, 2'd1, 1'b1, 64'h2006, 64'h0, 1, 1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_misalign();
    test_random();
    test_back_to_back();
    @(negedge clk);
    idle_inputs();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
